ntt_wb_sched: RTL and testbench
===============================

# ntt_wb_sched

Read/write-back scheduler that sits on the consumer side of `addrgen` in the NTT/INTT core. It turns each butterfly address pair into a coefficient-RAM read. It delays the pair through a `LAT`-deep tag pipeline that matches the butterfly datapath, then issues the matching write-back. It drives the INTT final-scale enable and reports end of transform only after the last write retires.

## Interface
Parameters:
- `LAT`, 4: cycles from `rd_en` to the matching `wr_en`; legal range 1..8.
- `AW`, 8: coefficient address width (256 coefficients).
- `ZW`, 7: twiddle index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_active` in 1: the address pair from `addrgen` is valid this cycle.
- `in_addr_up`, `in_addr_dn` in AW: butterfly operand addresses.
- `in_zeta_idx` in ZW: twiddle index.
- `in_last_stage` in 1: pair belongs to the final stage.
- `in_done` in 1: one-cycle pulse from `addrgen` at end of its sequence.
- `in_sel` in 1: 0 = NTT, 1 = INTT.
- `rd_en` out 1: strobe for the RAM read.
- `rd_addr_a`, `rd_addr_b` out AW: RAM read addresses.
- `zeta_idx` out ZW: twiddle ROM address.
- `wr_en` out 1: strobe for the RAM write.
- `wr_addr_a`, `wr_addr_b` out AW: RAM write addresses.
- `scale_en` out 1: multiply write data by n⁻¹ (INTT, final stage).
- `mode` out 1: latched `in_sel` for the current run.
- `busy` out 1: run in progress.
- `o_done` out 1: one-cycle pulse after the last write-back.
- `err_overlap` out 1: sticky; a new run started before `o_done`.
- `hazard` out 1: sticky read-after-write hazard flag (macro-gated).
- `hazard_cnt` out 8: saturating hazard count (macro-gated).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on `in_active`. `in_sel` is latched into `mode` on that edge, and that first pair is accepted.
- RUN→DRAIN on the first edge with `in_done` seen (same edge or latched earlier) and `in_active`=0.
- DRAIN→DONE when the tag pipeline holds no valid entries.
- DONE→IDLE unconditionally after one cycle. `o_done`=1 only in DONE.
- `in_done` in IDLE with no accepted pairs: go directly to DONE (empty run).
- Every edge with `in_active`=1 loads a tag: {valid, up, dn, last_stage}.
- The tag pipeline is a pure shift register that advances every cycle with no stall. Accepted pairs are never dropped.
- `in_active` in DRAIN or DONE:
  - the pair is accepted;
  - `err_overlap` is set;
  - the FSM returns to RUN and the pending done flag is cleared.
- `scale_en` = `wr_en` & tag.last_stage & `mode`.
- `busy` = state ≠ IDLE.
- `mode` holds its value until the next IDLE→RUN transition.
- Reset mid-run clears all state and tags, and discards pending writes. No `o_done` is issued.

## Timing
- A pair sampled on edge k gives `rd_en`/`rd_addr_*`/`zeta_idx` valid from edge k to edge k+1.
- The same pair gives `wr_en`/`wr_addr_*`/`scale_en` valid from edge k+LAT to edge k+LAT+1.
- Last pair on edge k_last, with `in_done` at or before k_last+LAT: `o_done` is high from edge k_last+LAT+1 for exactly one cycle.
- Back-to-back pairs give back-to-back strobes. Throughput is one pair per cycle.
- Reset values: every output 0; state IDLE; all tags invalid.
- Address outputs hold their last value when the corresponding strobe is 0.

## Configuration
- Macro `NTT_WB_HAZARD_CHK_EN`.
- Defined:
  - each accepted read compares `in_addr_up`/`in_addr_dn` against `up`/`dn` of all valid in-flight tags;
  - any match sets sticky `hazard` and increments `hazard_cnt`, saturating at 255;
  - both are cleared only by reset.
- Undefined: `hazard` and `hazard_cnt` are tied to 0 and no comparators are built.

## Structure
- Shared package `ntt_pkg` holds:
  - `N`=256 and `LOG_N`=8;
  - `AW` and `ZW` defaults;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the tag struct {valid, up, dn, last}.
- One sub-module, `ntt_tag_pipe`: a LAT-deep tag shift register. It exposes the output tag, an any-valid flag and all tags for the hazard compare.

## Test plan
- **Single pair, LAT=4.** Stimulus: `in_active` for one edge with up=0x00, dn=0x80, zeta=1, then `in_done`. Required:
  - `rd_en` for one cycle with rd_addr 0x00/0x80;
  - `wr_en` 4 cycles later with the same addresses;
  - `o_done` one cycle after `wr_en`.
- **Full NTT, Sel=0.** Stimulus: 7 stages × 128 = 896 consecutive pairs. Required:
  - 896 `rd_en` and 896 `wr_en` strobes;
  - `scale_en` never asserts;
  - `o_done` at edge k_last+5.
- **Full INTT, Sel=1.** Required:
  - `mode`=1 for the whole run;
  - `scale_en` exactly on the 128 final-stage writes.
- **Reset mid-run.** Stimulus: `rst_n` low at pair 300, then `in_done`. Required:
  - all outputs 0 immediately;
  - no `wr_en` and no `o_done` afterwards.
- **Overlap.** Stimulus: a new `in_active` 2 cycles after the last pair of the previous run. Required:
  - `err_overlap`=1;
  - all writes of both runs appear;
  - a single `o_done` after the second run drains.
- **Hazard (macro defined).** Stimulus: read 0x10 followed one cycle later by read 0x10. Required: `hazard`=1, `hazard_cnt`=1. With the macro undefined, both stay 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT/INTT core: sizes, scheduler states,
// the in-flight write-back tag and the tag address-conflict test.
package ntt_pkg;

    localparam int N      = 256;
    localparam int LOG_N  = 8;
    localparam int AW_DEF = 8;
    localparam int ZW_DEF = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] up;
        logic [AW_DEF-1:0] dn;
        logic              last;
    } tag_t;

    // True when a valid tag touches either address of the incoming pair
    function automatic logic tag_hit(input tag_t t, input logic [AW_DEF-1:0] a,
                                     input logic [AW_DEF-1:0] b);
        logic match;
        match = (t.up == a) | (t.up == b) | (t.dn == a) | (t.dn == b);
        return t.valid & match;
    endfunction

endpackage

// File: rtl/ntt_tag_pipe.sv
// LAT-deep free-running shift register of write-back tags; never stalls,
// exposes the oldest tag, an any-valid flag and every stage for hazard compares.
module ntt_tag_pipe
    import ntt_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  tag_t               tag_in,
    output tag_t               tag_out,
    output logic               any_valid,
    output tag_t [LAT-1:0]     tags
);

    tag_t [LAT-1:0] tags_q;
    tag_t [LAT-1:0] tags_d;
    logic           any_valid_s;

    // Shift every stage by one; stage 0 takes the newly accepted pair
    always_comb begin
        tags_d    = tags_q;
        tags_d[0] = tag_in;
        for (int i = 1; i < LAT; i++) begin
            tags_d[i] = tags_q[i-1];
        end
    end

    // Reduce the stage valid bits so the scheduler knows when it has drained
    always_comb begin
        any_valid_s = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_valid_s = any_valid_s | tags_q[i].valid;
        end
    end

    // Tag storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign tag_out   = tags_q[LAT-1];
    assign any_valid = any_valid_s;
    assign tags      = tags_q;

endmodule

// File: rtl/ntt_wb_sched.sv
// NTT read/write-back scheduler: issues RAM reads for addrgen pairs, the matching
// writes LAT cycles later, and o_done after the last write. Hazard monitor: NTT_WB_HAZARD_CHK_EN.
module ntt_wb_sched
    import ntt_pkg::*;
#(
    parameter int LAT = 4,
    parameter int AW  = AW_DEF,
    parameter int ZW  = ZW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_active,
    input  logic [AW-1:0] in_addr_up,
    input  logic [AW-1:0] in_addr_dn,
    input  logic [ZW-1:0] in_zeta_idx,
    input  logic          in_last_stage,
    input  logic          in_done,
    input  logic          in_sel,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [ZW-1:0] zeta_idx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic          scale_en,
    output logic          mode,
    output logic          busy,
    output logic          o_done,
    output logic          err_overlap,
    output logic          hazard,
    output logic [7:0]    hazard_cnt
);

    state_e         state_q, state_d;
    logic           done_pend_q, done_pend_d;
    logic           mode_q, mode_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           o_done_q, o_done_d;
    logic           rd_en_q, rd_en_d;
    logic [AW-1:0]  rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0]  rd_addr_b_q, rd_addr_b_d;
    logic [ZW-1:0]  zeta_q, zeta_d;
    logic           wr_en_q, wr_en_d;
    logic [AW-1:0]  wr_addr_a_q, wr_addr_a_d;
    logic [AW-1:0]  wr_addr_b_q, wr_addr_b_d;
    logic           scale_q, scale_d;

    tag_t           tag_in_s;
    tag_t           tag_out_s;
    tag_t [LAT-1:0] tags_s;
    logic           any_valid_s;

    assign tag_in_s = '{valid: in_active,
                        up:    AW_DEF'(in_addr_up),
                        dn:    AW_DEF'(in_addr_dn),
                        last:  in_last_stage};

    ntt_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (tag_in_s),
        .tag_out   (tag_out_s),
        .any_valid (any_valid_s),
        .tags      (tags_s)
    );

    // Run control; a pair arriving while draining restarts the run and flags the overlap
    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        mode_d      = mode_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_active) begin
                    state_d     = RUN;
                    mode_d      = in_sel;
                    done_pend_d = in_done;
                end else if (in_done) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if ((in_done || done_pend_q) && !in_active) begin
                    state_d     = DRAIN;
                    done_pend_d = 1'b0;
                end else begin
                    state_d     = RUN;
                    done_pend_d = done_pend_q | in_done;
                end
            end
            DRAIN: begin
                if (in_active) begin
                    state_d     = RUN;
                    err_d       = 1'b1;
                    done_pend_d = in_done;
                end else if (!any_valid_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (in_active) begin
                    state_d     = RUN;
                    err_d       = 1'b1;
                    done_pend_d = in_done;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                done_pend_d = 1'b0;
            end
        endcase
        busy_d   = (state_d != IDLE);
        o_done_d = (state_d == DONE);
    end

    // Read and write strobes; addresses hold while their strobe is low
    always_comb begin
        rd_en_d     = in_active;
        rd_addr_a_d = in_active ? in_addr_up : rd_addr_a_q;
        rd_addr_b_d = in_active ? in_addr_dn : rd_addr_b_q;
        zeta_d      = in_active ? in_zeta_idx : zeta_q;
        wr_en_d     = tag_out_s.valid;
        wr_addr_a_d = tag_out_s.valid ? AW'(tag_out_s.up) : wr_addr_a_q;
        wr_addr_b_d = tag_out_s.valid ? AW'(tag_out_s.dn) : wr_addr_b_q;
        scale_d     = tag_out_s.valid & tag_out_s.last & mode_q;
    end

    // FSM state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_pend_q <= 1'b0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            o_done_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            zeta_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            scale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            o_done_q    <= o_done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            zeta_q      <= zeta_d;
            wr_en_q     <= wr_en_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
            scale_q     <= scale_d;
        end
    end

`ifdef NTT_WB_HAZARD_CHK_EN
    logic       hit_s;
    logic       hazard_q, hazard_d;
    logic [7:0] hcnt_q, hcnt_d;

    // Cross-compare the accepted pair against every in-flight tag; count saturates
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            hit_s = hit_s | tag_hit(tags_s[i], AW_DEF'(in_addr_up), AW_DEF'(in_addr_dn));
        end
        hit_s    = hit_s & in_active;
        hazard_d = hazard_q | hit_s;
        if (hit_s && (hcnt_q != 8'hFF)) begin
            hcnt_d = hcnt_q + 8'd1;
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Hazard flag and counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_q <= 1'b0;
            hcnt_q   <= 8'd0;
        end else begin
            hazard_q <= hazard_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign hazard     = hazard_q;
    assign hazard_cnt = hcnt_q;
`else
    logic unused_tags_s;
    assign unused_tags_s = ^tags_s;
    assign hazard        = 1'b0;
    assign hazard_cnt    = 8'd0;
`endif

    assign rd_en       = rd_en_q;
    assign rd_addr_a   = rd_addr_a_q;
    assign rd_addr_b   = rd_addr_b_q;
    assign zeta_idx    = zeta_q;
    assign wr_en       = wr_en_q;
    assign wr_addr_a   = wr_addr_a_q;
    assign wr_addr_b   = wr_addr_b_q;
    assign scale_en    = scale_q;
    assign mode        = mode_q;
    assign busy        = busy_q;
    assign o_done      = o_done_q;
    assign err_overlap = err_q;

endmodule

// File: tb/tb_ntt_wb_sched.sv
// Directed bench for ntt_wb_sched: cycle-vector table plus full NTT/INTT, reset, overlap
// and hazard sequences checked against a write-back scoreboard.
module tb_ntt_wb_sched;

    localparam int LAT = 4;

    typedef struct packed {
        logic       act;
        logic [7:0] up;
        logic [7:0] dn;
        logic [6:0] z;
        logic       last;
        logic       done;
        logic       sel;
    } in_t;

    typedef struct packed {
        logic       rd;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [6:0] z;
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wb;
        logic       sc;
        logic       md;
        logic       bs;
        logic       od;
        logic       er;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct packed {
        logic [7:0] up;
        logic [7:0] dn;
        logic       last;
    } wexp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_active = 1'b0;
    logic [7:0] in_addr_up = 8'd0;
    logic [7:0] in_addr_dn = 8'd0;
    logic [6:0] in_zeta_idx = 7'd0;
    logic       in_last_stage = 1'b0;
    logic       in_done = 1'b0;
    logic       in_sel = 1'b0;
    logic       rd_en, wr_en, scale_en, mode, busy, o_done, err_overlap, hazard;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, hazard_cnt;
    logic [6:0] zeta_idx;

    int n_checks = 0;
    int n_fail = 0;
    int ncyc = 0;
    bit mon_en = 1'b0;
    logic exp_mode = 1'b0;
    int rd_cnt, wr_cnt, wr_err, sc_cnt, od_cnt, od_cyc, mode_err, last_k;
    wexp_t wq[$];
    vec_t vecs[16];

    ntt_wb_sched #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_active(in_active), .in_addr_up(in_addr_up),
        .in_addr_dn(in_addr_dn), .in_zeta_idx(in_zeta_idx), .in_last_stage(in_last_stage),
        .in_done(in_done), .in_sel(in_sel), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .zeta_idx(zeta_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b), .scale_en(scale_en), .mode(mode), .busy(busy),
        .o_done(o_done), .err_overlap(err_overlap), .hazard(hazard), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t a;
        a = '{rd_en, rd_addr_a, rd_addr_b, zeta_idx, wr_en, wr_addr_a, wr_addr_b,
              scale_en, mode, busy, o_done, err_overlap};
        return a;
    endfunction

    task automatic monitor();
        wexp_t e;
        if (mon_en) begin
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    wr_err++;
                end else begin
                    e = wq.pop_front();
                    if (wr_addr_a !== e.up || wr_addr_b !== e.dn || scale_en !== (e.last & exp_mode))
                        wr_err++;
                end
            end
            if (scale_en) sc_cnt++;
            if (busy && mode !== exp_mode) mode_err++;
            if (o_done) begin
                od_cnt++;
                od_cyc = ncyc;
            end
        end
    endtask

    // One clock: sample what the previous edge produced, then drive the next inputs
    task automatic step(input in_t v);
        @(negedge clk);
        ncyc++;
        monitor();
        in_active     = v.act;
        in_addr_up    = v.up;
        in_addr_dn    = v.dn;
        in_zeta_idx   = v.z;
        in_last_stage = v.last;
        in_done       = v.done;
        in_sel        = v.sel;
    endtask

    task automatic send_pair(input logic [7:0] up, input logic [7:0] dn, input logic [6:0] z,
                             input logic last, input logic sel);
        in_t v;
        v = '{1'b1, up, dn, z, last, 1'b0, sel};
        step(v);
        wq.push_back('{up, dn, last});
        last_k = ncyc + 1;
    endtask

    task automatic send_ctl(input logic done, input logic sel);
        in_t v;
        v = '{1'b0, 8'd0, 8'd0, 7'd0, 1'b0, done, sel};
        step(v);
    endtask

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; wr_err = 0; sc_cnt = 0;
        od_cnt = 0; od_cyc = -1; mode_err = 0;
        wq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_active = 1'b0; in_done = 1'b0; in_sel = 1'b0; in_last_stage = 1'b0;
        in_addr_up = 8'd0; in_addr_dn = 8'd0; in_zeta_idx = 7'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stage_pair(input int s, input int j, output logic [7:0] up, output logic [7:0] dn);
        int len;
        int u;
        len = 128 >> s;
        u   = (j / len) * 2 * len + (j % len);
        up  = 8'(u);
        dn  = 8'(u + len);
    endtask

    task automatic run_full(input logic sel, input string nm);
        logic [7:0] up, dn;
        do_reset();
        clear_mon();
        exp_mode = sel;
        mon_en   = 1'b1;
        for (int s = 0; s < 7; s++) begin
            for (int j = 0; j < 128; j++) begin
                stage_pair(s, j, up, dn);
                send_pair(up, dn, 7'((1 << s) + j), (s == 6), sel);
            end
        end
        send_ctl(1'b1, sel);
        repeat (20) send_ctl(1'b0, sel);
        mon_en = 1'b0;
        chk({nm, "_rd_cnt"}, 64'(rd_cnt), 64'd896);
        chk({nm, "_wr_cnt"}, 64'(wr_cnt), 64'd896);
        chk({nm, "_wr_seq"}, 64'(wr_err), 64'd0);
        chk({nm, "_scale_cnt"}, 64'(sc_cnt), sel ? 64'd128 : 64'd0);
        chk({nm, "_mode"}, 64'(mode_err), 64'd0);
        chk({nm, "_odone_cnt"}, 64'(od_cnt), 64'd1);
        chk({nm, "_odone_cyc"}, 64'(od_cyc), 64'(last_k + LAT + 1));
        chk({nm, "_err_overlap"}, 64'(err_overlap), 64'd0);
    endtask

    initial begin
        logic [7:0] up, dn;
        out_t got;

        // Single NTT pair, empty run, single INTT final-stage pair with in_done on the same edge
        vecs[0]  = '{'{1'b1, 8'h00, 8'h80, 7'h01, 1'b0, 1'b0, 1'b0}, '{1'b1, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b1, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[2]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[5]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[6]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b1, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[8]  = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 8'h80, 7'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{'{1'b1, 8'h12, 8'h13, 7'h7f, 1'b1, 1'b1, 1'b1}, '{1'b1, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[11] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[12] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[13] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b1, 8'h12, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[14] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h12, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}};
        vecs[15] = '{'{1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h12, 8'h13, 7'h7f, 1'b0, 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};

        do_reset();
        @(posedge clk); #1;
        chk("reset_outputs", 64'(sample()), 64'd0);
        chk("reset_hazard", 64'({hazard, hazard_cnt}), 64'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].i);
            @(posedge clk); #1;
            got = sample();
            chk($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].o));
        end

        run_full(1'b0, "ntt");
        run_full(1'b1, "intt");

        // Reset at pair 300; in_done arrives while reset is still held
        do_reset();
        clear_mon();
        exp_mode = 1'b0;
        mon_en   = 1'b1;
        for (int p = 0; p < 300; p++) begin
            stage_pair(p / 128, p % 128, up, dn);
            send_pair(up, dn, 7'd3, 1'b0, 1'b0);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({sample(), hazard, hazard_cnt}), 64'd0);
        clear_mon();
        send_ctl(1'b1, 1'b0);
        send_ctl(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (15) send_ctl(1'b0, 1'b0);
        mon_en = 1'b0;
        chk("rst_mid_no_wr", 64'(wr_cnt), 64'd0);
        chk("rst_mid_no_odone", 64'(od_cnt), 64'd0);
        chk("rst_mid_idle", 64'(busy), 64'd0);

        // Second run starts while the first is draining
        do_reset();
        clear_mon();
        exp_mode = 1'b0;
        mon_en   = 1'b1;
        for (int j = 0; j < 10; j++) send_pair(8'(j), 8'(j + 128), 7'd1, 1'b0, 1'b0);
        send_ctl(1'b1, 1'b0);
        for (int j = 0; j < 10; j++) send_pair(8'(j + 32), 8'(j + 160), 7'd2, 1'b0, 1'b0);
        send_ctl(1'b1, 1'b0);
        repeat (20) send_ctl(1'b0, 1'b0);
        mon_en = 1'b0;
        chk("ovl_err", 64'(err_overlap), 64'd1);
        chk("ovl_wr_cnt", 64'(wr_cnt), 64'd20);
        chk("ovl_wr_seq", 64'(wr_err), 64'd0);
        chk("ovl_odone_cnt", 64'(od_cnt), 64'd1);
        chk("ovl_odone_cyc", 64'(od_cyc), 64'(last_k + LAT + 1));

        // Back-to-back reads of the same pair
        do_reset();
        clear_mon();
        send_pair(8'h10, 8'h90, 7'd5, 1'b0, 1'b0);
        send_pair(8'h10, 8'h90, 7'd5, 1'b0, 1'b0);
        send_ctl(1'b1, 1'b0);
        repeat (10) send_ctl(1'b0, 1'b0);
`ifdef NTT_WB_HAZARD_CHK_EN
        chk("hazard_flag", 64'(hazard), 64'd1);
        chk("hazard_cnt", 64'(hazard_cnt), 64'd1);
`else
        chk("hazard_flag", 64'(hazard), 64'd0);
        chk("hazard_cnt", 64'(hazard_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
